// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage that sits directly after Execute. Operations that do not touch
//   memory pass the ALU result straight to write-back, one per cycle. Loads and
//   stores run a single req/ack transaction on the data bus. The stage handles
//   byte lanes and load extension, and stalls upstream while the bus is
//   outstanding. A bus that never acks is abandoned after TIMEOUT_CYCLES.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   valid_in            Execute presents an operation
//   alu_result          effective address or pass-through value
//   store_data          store operand
//   mem_read/mem_write  load / store (both set executes as a store)
//   mem_size            0=byte 1=half 2=word 3=word
//   mem_unsigned        zero-extend loads when set
//   stall               upstream must hold its inputs
//   mem_req/mem_we      bus request / write enable
//   mem_addr/mem_be     word-aligned address / little-endian byte enables
//   mem_wdata           lane-replicated write data
//   mem_ack/mem_rdata   bus completion pulse / read data
//   wb_valid/wb_data    one-cycle result to write-back
//   misalign_err        pulse with wb_valid for a misaligned access
//   bus_err             pulse with wb_valid for a bus timeout
//
// state | meaning
// IDLE  | waiting for an operation; non-bus results retire from here
// BUSY  | mem_req held, waiting for mem_ack or timeout
// RESP  | result presented to write-back for one cycle

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             uns_q;

  logic             is_mem;
  logic             misaligned;
  logic             accept;
  logic             timeout_hit;
  logic [3:0]       be_calc;
  logic [31:0]      wdata_calc;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_ext;

  assign is_mem = mem_read | mem_write;

  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = store_data;
    case (mem_size)
      2'd0: begin
        be_calc    = 4'b0001 << alu_result[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      2'd1: begin
        misaligned = alu_result[0];
        be_calc    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{store_data[15:0]}};
      end
      default: misaligned = |alu_result[1:0];
    endcase
  end

  assign accept = (state == IDLE) && valid_in && is_mem && !misaligned;

  // Terminal count is one below the limit: the check happens in the cycle that
  // would be the last one without an ack, so mem_req is high TIMEOUT_CYCLES cycles.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          stall     = 1'b1;
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack || timeout_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write enable only while the request is live so the bus never sees a
  // stale write strobe between transactions.
  assign mem_we = we_q & (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      we_q         <= 1'b0;
      lane_q       <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_data  <= alu_result;
            end else if (misaligned) begin
              wb_valid     <= 1'b1;
              wb_data      <= '0;
              misalign_err <= 1'b1;
            end else begin
              mem_addr  <= {alu_result[31:2], 2'b00};
              lane_q    <= alu_result[1:0];
              mem_be    <= be_calc;
              mem_wdata <= wdata_calc;
              we_q      <= mem_write;
              size_q    <= mem_size;
              uns_q     <= mem_unsigned;
              cnt       <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            wb_valid <= 1'b1;
            wb_data  <= we_q ? 32'd0 : load_ext;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (timeout_hit) begin
              wb_valid <= 1'b1;
              wb_data  <= '0;
              bus_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic        mem_unsigned = 1'b0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        bus_err;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        berr;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  wb_t  exp_wb[$];
  bus_t exp_bus[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
    return (int'(addr[1:0]) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] be;
    int a, nb;
    nb = nbytes(size);
    a  = int'(addr[1:0]);
    be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + nb);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] sd, input logic [1:0] size);
    logic [31:0] w;
    int nb;
    nb = nbytes(size);
    w  = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic [1:0] size, input logic uns);
    logic [31:0] v, mask;
    int nb;
    nb = nbytes(size);
    if (nb == 4) return rdata;
    v    = rdata >> (8 * int'(addr[1:0]));
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v    = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic prev_req = 1'b0;
  logic have_bus = 1'b0;
  bus_t cur_bus;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      have_bus = 1'b0;
    end else begin
      if (wb_valid) begin
        if (exp_wb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_unexpected: got wb_valid=1 wb_data=%h, required no output", wb_data);
        end else begin
          wb_t e;
          e = exp_wb.pop_front();
          check("wb_data", wb_data, e.data);
          check("misalign_err", 32'(misalign_err), 32'(e.mis));
          check("bus_err", 32'(bus_err), 32'(e.berr));
        end
      end else if (misalign_err || bus_err) begin
        n_tests++;
        n_fail++;
        $display("FAIL err_without_wb: got misalign_err=%b bus_err=%b, required 0", misalign_err, bus_err);
      end
      if (mem_req) begin
        if (!prev_req) begin
          if (exp_bus.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_unexpected: got mem_req=1 addr=%h, required no request", mem_addr);
            have_bus = 1'b0;
          end else begin
            cur_bus  = exp_bus.pop_front();
            have_bus = 1'b1;
          end
        end
        if (have_bus) begin
          check("mem_addr", mem_addr, cur_bus.addr);
          check("mem_be", 32'(mem_be), 32'(cur_bus.be));
          check("mem_we", 32'(mem_we), 32'(cur_bus.we));
          if (cur_bus.we) check("mem_wdata", mem_wdata, cur_bus.wdata);
        end
      end
      prev_req = mem_req;
    end
  end

  // ---------------- stimulus ----------------
  // k = number of BUSY cycles without ack before the ack; k >= TO never acks.
  // resp_pt presents a pass-through op during RESP, which must be taken once, in IDLE.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                        input int k, input bit resp_pt);
    wb_t  w;
    bus_t b;
    logic [31:0] pt_val;
    @(posedge clk); #1;
    valid_in     = 1'b1;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = size;
    mem_unsigned = uns;
    alu_result   = addr;
    store_data   = sd;
    mem_ack      = 1'($urandom_range(0, 1));
    mem_rdata    = $urandom;
    if (!rd && !wr) begin
      w = '{data: addr, mis: 1'b0, berr: 1'b0};
      exp_wb.push_back(w);
      @(negedge clk);
      check("stall_passthru", 32'(stall), 32'd0);
      return;
    end
    if (model_misaligned(addr, size)) begin
      w = '{data: 32'd0, mis: 1'b1, berr: 1'b0};
      exp_wb.push_back(w);
      @(negedge clk);
      check("stall_misalign", 32'(stall), 32'd0);
      return;
    end
    b = '{addr: {addr[31:2], 2'b00}, be: model_be(addr, size), wdata: model_wdata(sd, size), we: wr};
    exp_bus.push_back(b);
    if (k >= TO)  w = '{data: 32'd0, mis: 1'b0, berr: 1'b1};
    else if (wr)  w = '{data: 32'd0, mis: 1'b0, berr: 1'b0};
    else          w = '{data: model_load(rdata, addr, size, uns), mis: 1'b0, berr: 1'b0};
    exp_wb.push_back(w);
    @(negedge clk);
    check("stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    valid_in     = 1'b0;
    alu_result   = $urandom;
    store_data   = $urandom;
    mem_size     = 2'($urandom_range(0, 3));
    mem_unsigned = 1'($urandom_range(0, 1));
    for (int c = 0; c < TO; c++) begin
      mem_ack   = (c == k);
      mem_rdata = (c == k) ? rdata : $urandom;
      @(negedge clk);
      check("req_busy", 32'(mem_req), 32'd1);
      check("stall_busy", 32'(stall), 32'd1);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (c == k) break;
    end
    if (resp_pt) begin
      pt_val     = $urandom;
      valid_in   = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_result = pt_val;
      w = '{data: pt_val, mis: 1'b0, berr: 1'b0};
      exp_wb.push_back(w);
    end
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("req_resp", 32'(mem_req), 32'd0);
    check("stall_resp", 32'(stall), 32'd0);
    if (resp_pt) @(posedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      mem_ack  = 1'b0;
    end
  endtask

  task automatic reset_mid_op();
    bus_t b;
    @(posedge clk); #1;
    valid_in     = 1'b1;
    mem_read     = 1'b1;
    mem_write    = 1'b0;
    mem_size     = 2'd2;
    mem_unsigned = 1'b0;
    alu_result   = 32'h0000_0400;
    mem_ack      = 1'b0;
    b = '{addr: 32'h0000_0400, be: 4'b1111, wdata: 32'd0, we: 1'b0};
    exp_bus.push_back(b);
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_be", 32'(mem_be), 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_errs", 32'({misalign_err, bus_err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // pass-through, back to back
    run_op(0, 0, 2'd0, 0, 32'h0000_1234, 32'd0, 32'd0, 0, 0);
    run_op(0, 0, 2'd2, 0, 32'hCAFE_0001, 32'd0, 32'd0, 0, 0);
    idle_cycles(1);
    // byte store to lane 3
    run_op(0, 1, 2'd0, 0, 32'h0000_0103, 32'hAABB_CCDD, 32'd0, 2, 0);
    idle_cycles(1);
    // half loads, signed and unsigned
    run_op(1, 0, 2'd1, 0, 32'h0000_0202, 32'd0, 32'h8001_7FFF, 1, 0);
    run_op(1, 0, 2'd1, 1, 32'h0000_0202, 32'd0, 32'h8001_7FFF, 0, 0);
    idle_cycles(1);
    // misaligned word load
    run_op(1, 0, 2'd2, 0, 32'h0000_0006, 32'd0, 32'd0, 0, 0);
    idle_cycles(1);
    // timeout, then ack on the last allowed cycle
    run_op(1, 0, 2'd2, 0, 32'h0000_0010, 32'd0, 32'h1234_5678, TO, 0);
    run_op(1, 0, 2'd2, 0, 32'h0000_0014, 32'd0, 32'h1234_5678, TO - 1, 0);
    // read+write executes as store; reserved size behaves as word
    run_op(1, 1, 2'd3, 0, 32'h0000_0020, 32'h0102_0304, 32'hFFFF_FFFF, 0, 1);
    run_op(1, 0, 2'd3, 0, 32'h0000_0024, 32'd0, 32'h89AB_CDEF, 3, 0);
    run_op(1, 0, 2'd0, 0, 32'h0000_0031, 32'd0, 32'h0000_8000, 0, 0);
    idle_cycles(2);
    // reset mid-transaction, then normal operation
    reset_mid_op();
    run_op(0, 0, 2'd0, 0, 32'h0000_BEEF, 32'd0, 32'd0, 0, 0);
    idle_cycles(2);

    for (int i = 0; i < 250; i++) begin
      logic rd, wr, uns;
      logic [1:0] size;
      logic [31:0] addr;
      int r, k, nb;
      r    = $urandom_range(0, 9);
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      if (r < 2) begin
        rd = 0; wr = 0;
      end else begin
        rd = 1'($urandom_range(0, 1));
        wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      addr = $urandom;
      nb   = nbytes(size);
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'(int'(addr[1:0]) - (int'(addr[1:0]) % nb));
      r = $urandom_range(0, 19);
      if (r < 16)       k = r % 5;
      else if (r == 16) k = TO - 1;
      else if (r == 17) k = TO;
      else              k = 0;
      run_op(rd, wr, size, uns, addr, $urandom, $urandom, k, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) idle_cycles(1);
    end
    idle_cycles(2);

    for (int i = 0; i < 50 && (exp_wb.size() != 0 || exp_bus.size() != 0); i++) @(posedge clk);
    check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
    check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
